// File: rtl/uart_rx_fifo_rcv_pkg.sv
// Shared definitions for the fpga_rx UART receiver: FSM states and default baud timing
// (the default baud timing is shared with the transmitter).
package uart_rx_fifo_rcv_pkg;

  localparam int unsigned CLK_HZ             = 24_000_000;
  localparam int unsigned BAUD               = 115_200;
  localparam int unsigned DEFAULT_BIT_CYCLES = CLK_HZ / BAUD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo_rcv_sync_fifo.sv
// Show-ahead synchronous FIFO: registered storage, wrapping pointers and a separate
// occupancy count. A push into a full FIFO is accepted only when a pop frees a slot.
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic             overrun
);

  localparam int unsigned            DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0]  PTR_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]    CNT_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]    CNT_FULL = DEPTH[DEPTH_LOG2:0];

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  empty;
  logic                  full;
  logic                  pop_ok;
  logic                  push_ok;

  always_comb begin
    empty    = (count == '0);
    full     = (count == CNT_FULL);
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    overrun  = push && full && !pop_ok;
    valid    = !empty;
    pop_data = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo_rcv.sv
// UART receiver on fpga_rx (8N1, or 8E1 when UART_RX_PARITY_EN is defined), mid-bit
// sampling, feeding a show-ahead FIFO popped with a valid/ready handshake.
module uart_rx_fifo_rcv
  import uart_rx_fifo_rcv_pkg::*;
#(
  parameter int unsigned BIT_CYCLES      = DEFAULT_BIT_CYCLES,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fpga_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam logic [15:0] HALF_LOAD = 16'(BIT_CYCLES / 2 - 1);
  localparam logic [15:0] FULL_LOAD = 16'(BIT_CYCLES - 1);

  rx_state_t   state, state_n;
  logic        rx_meta, rxd_s;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic        push;
  logic        tick;
`ifdef UART_RX_PARITY_EN
  logic        par_bad, par_bad_n;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxd_s   <= 1'b1;
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      rx_meta <= fpga_rx;
      rxd_s   <= rx_meta;
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push      = 1'b0;
    frame_err = 1'b0;
    tick      = (cnt == '0);
`ifdef UART_RX_PARITY_EN
    par_bad_n  = par_bad;
    parity_err = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (!rxd_s) begin
          cnt_n   = HALF_LOAD;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (!tick) begin
          cnt_n = cnt - 16'd1;
        end else if (!rxd_s) begin
          cnt_n     = FULL_LOAD;
          bit_idx_n = '0;
          state_n   = ST_DATA;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (!tick) begin
          cnt_n = cnt - 16'd1;
        end else begin
          shreg_n = {rxd_s, shreg[7:1]};
          cnt_n   = FULL_LOAD;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (!tick) begin
          cnt_n = cnt - 16'd1;
        end else begin
          par_bad_n = (^shreg) ^ rxd_s;
          cnt_n     = FULL_LOAD;
          state_n   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (!tick) begin
          cnt_n = cnt - 16'd1;
        end else if (rxd_s) begin
          push    = 1'b1;
          state_n = ST_IDLE;
`ifdef UART_RX_PARITY_EN
          parity_err = par_bad;
`endif
        end else begin
          // bad stop bit: drop the byte and park until the line idles again
          frame_err = 1'b1;
          state_n   = ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        if (rxd_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    rx_busy = (state != ST_IDLE);
  end

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shreg),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .valid     (rx_valid),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_uart_rx_fifo_rcv.sv
// Self-checking bench for uart_rx_fifo_rcv with BIT_CYCLES=16 and a 4-entry FIFO.
module tb_uart_rx_fifo_rcv;

  localparam int BITC = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_EXTRA = 1;
`else
  localparam int FRAME_EXTRA = 0;
`endif
  // cycles from the start edge to rx_valid: 9.5 (or 10.5) bit times plus the synchronizer
  localparam int LAT_NOM = (BITC * (19 + 2 * FRAME_EXTRA)) / 2 + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fpga_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int pass_cnt = 0;
  int check_cnt = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, dbl_cnt = 0;
  logic fe_prev = 1'b0, ov_prev = 1'b0, pe_prev = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo_rcv #(
    .BIT_CYCLES      (BITC),
    .FIFO_DEPTH_LOG2 (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fpga_rx   (fpga_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_busy   (rx_busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if ((frame_err && fe_prev) || (overrun && ov_prev)) dbl_cnt++;
    fe_prev = frame_err;
    ov_prev = overrun;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt++;
    if (parity_err && pe_prev) dbl_cnt++;
    pe_prev = parity_err;
`endif
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // serial frame: start, 8 data LSB first, optional parity, stop; line left idle high
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    @(posedge clk);
    #1 fpga_rx = 1'b0;
    repeat (BITC) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      fpga_rx = b[i];
      repeat (BITC) @(posedge clk);
      #1;
    end
    if (FRAME_EXTRA == 1) begin
      fpga_rx = par;
      repeat (BITC) @(posedge clk);
      #1;
    end
    fpga_rx = stop;
    repeat (BITC) @(posedge clk);
    #1 fpga_rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, ^b, 1'b1);
  endtask

  task automatic pop_byte(output logic [7:0] d, output logic v);
    v = rx_valid;
    d = rx_data;
    if (v) begin
      rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge clk); #1;
    check_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", rx_valid); else pass_cnt++;
    check_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", rx_data); else pass_cnt++;
    check_cnt++; if (rx_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", rx_busy); else pass_cnt++;
    check_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got=%b exp=0", frame_err); else pass_cnt++;
    check_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun got=%b exp=0", overrun); else pass_cnt++;
    rx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rx_ready = 1'b0;
    check_cnt++; if (rx_valid !== 1'b0) $display("FAIL pop_empty_valid got=%b exp=0", rx_valid); else pass_cnt++;
  endtask

  task automatic test_basic();
    int lat;
    logic [7:0] d;
    logic v;
    lat = 0;
    fork
      send_byte(8'h55);
      begin
        @(posedge clk); #1;
        while (!rx_valid && lat < 400) begin
          @(posedge clk); #1;
          lat++;
        end
      end
    join
    check_cnt++;
    if (lat < LAT_NOM - 1 || lat > LAT_NOM + 1)
      $display("FAIL latency got=%0d exp=%0d+-1", lat, LAT_NOM);
    else pass_cnt++;
    send_byte(8'hA3);
    pop_byte(d, v);
    check_cnt++; if (v !== 1'b1 || d !== 8'h55) $display("FAIL head0 got=%b/%h exp=1/55", v, d); else pass_cnt++;
    pop_byte(d, v);
    check_cnt++; if (v !== 1'b1 || d !== 8'hA3) $display("FAIL head1 got=%b/%h exp=1/a3", v, d); else pass_cnt++;
    check_cnt++; if (rx_valid !== 1'b0) $display("FAIL drained_valid got=%b exp=0", rx_valid); else pass_cnt++;
  endtask

  task automatic test_break();
    int fe0, n;
    fpga_rx = 1'b0;
    do_reset();
    fe0 = fe_cnt;
    repeat (1000) @(posedge clk);
    #1;
    check_cnt++; if (fe_cnt - fe0 != 1) $display("FAIL break_frame_err got=%0d exp=1", fe_cnt - fe0); else pass_cnt++;
    check_cnt++; if (rx_busy !== 1'b1) $display("FAIL break_busy got=%b exp=1", rx_busy); else pass_cnt++;
    check_cnt++; if (rx_valid !== 1'b0) $display("FAIL break_valid got=%b exp=0", rx_valid); else pass_cnt++;
    fpga_rx = 1'b1;
    n = 0;
    while (rx_busy && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check_cnt++; if (rx_busy !== 1'b0) $display("FAIL break_release_busy got=%b exp=0 after=%0d", rx_busy, n); else pass_cnt++;
  endtask

  task automatic test_overrun();
    int ov0;
    logic [7:0] d;
    logic v;
    ov0 = ov_cnt;
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    check_cnt++; if (ov_cnt - ov0 != 1) $display("FAIL overrun_count got=%0d exp=1", ov_cnt - ov0); else pass_cnt++;
    for (int i = 1; i <= 4; i++) begin
      pop_byte(d, v);
      check_cnt++;
      if (v !== 1'b1 || d !== 8'(i)) $display("FAIL overrun_drain%0d got=%b/%h exp=1/%h", i, v, d, 8'(i));
      else pass_cnt++;
    end
    check_cnt++; if (rx_valid !== 1'b0) $display("FAIL overrun_empty got=%b exp=0", rx_valid); else pass_cnt++;
  endtask

  task automatic test_push_pop_full();
    int ov0;
    logic [7:0] d;
    logic v;
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    ov0 = ov_cnt;
    fork
      send_byte(8'h05);
      begin
        @(posedge clk);
        repeat (LAT_NOM) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    check_cnt++; if (ov_cnt - ov0 != 0) $display("FAIL full_pushpop_overrun got=%0d exp=0", ov_cnt - ov0); else pass_cnt++;
    for (int i = 2; i <= 5; i++) begin
      pop_byte(d, v);
      check_cnt++;
      if (v !== 1'b1 || d !== 8'(i)) $display("FAIL full_pushpop_drain%0d got=%b/%h exp=1/%h", i, v, d, 8'(i));
      else pass_cnt++;
    end
    check_cnt++; if (rx_valid !== 1'b0) $display("FAIL full_pushpop_empty got=%b exp=0", rx_valid); else pass_cnt++;
  endtask

  task automatic test_glitch();
    int fe0, n;
    logic seen_busy;
    fe0 = fe_cnt;
    seen_busy = 1'b0;
    @(posedge clk);
    #1 fpga_rx = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen_busy |= rx_busy;
    end
    fpga_rx = 1'b1;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      seen_busy |= rx_busy;
      if (!rx_busy && seen_busy) break;
    end
    check_cnt++; if (!seen_busy || rx_busy || n > 8) $display("FAIL glitch_idle got=busy%b seen%b after=%0d exp=idle within 8", rx_busy, seen_busy, n); else pass_cnt++;
    repeat (200) @(posedge clk);
    #1;
    check_cnt++; if (fe_cnt - fe0 != 0) $display("FAIL glitch_frame_err got=%0d exp=0", fe_cnt - fe0); else pass_cnt++;
    check_cnt++; if (rx_valid !== 1'b0) $display("FAIL glitch_push got=%b exp=0", rx_valid); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] b, d, e;
    logic v;
    int ov0, exp_ov, k;
    ov0 = ov_cnt;
    exp_ov = 0;
    for (int n = 0; n < 12; n++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 20)) @(posedge clk);
      send_byte(b);
      if (q.size() < 4) q.push_back(b);
      else exp_ov++;
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin
        pop_byte(d, v);
        check_cnt++;
        if (q.size() > 0) begin
          e = q.pop_front();
          if (v !== 1'b1 || d !== e) $display("FAIL random_pop got=%b/%h exp=1/%h", v, d, e);
          else pass_cnt++;
        end else begin
          if (v !== 1'b0) $display("FAIL random_pop_empty got=%b exp=0", v);
          else pass_cnt++;
        end
      end
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      pop_byte(d, v);
      check_cnt++;
      if (v !== 1'b1 || d !== e) $display("FAIL random_drain got=%b/%h exp=1/%h", v, d, e);
      else pass_cnt++;
    end
    check_cnt++; if (ov_cnt - ov0 != exp_ov) $display("FAIL random_overrun got=%0d exp=%0d", ov_cnt - ov0, exp_ov); else pass_cnt++;
    check_cnt++; if (rx_valid !== 1'b0) $display("FAIL random_empty got=%b exp=0", rx_valid); else pass_cnt++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int pe0;
    logic [7:0] d;
    logic v;
    pe0 = pe_cnt;
    send_frame(8'h07, 1'b0, 1'b1);
    check_cnt++; if (pe_cnt - pe0 != 1) $display("FAIL parity_bad_pulse got=%0d exp=1", pe_cnt - pe0); else pass_cnt++;
    pop_byte(d, v);
    check_cnt++; if (v !== 1'b1 || d !== 8'h07) $display("FAIL parity_bad_byte got=%b/%h exp=1/07", v, d); else pass_cnt++;
    pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    check_cnt++; if (pe_cnt - pe0 != 0) $display("FAIL parity_good_pulse got=%0d exp=0", pe_cnt - pe0); else pass_cnt++;
    pop_byte(d, v);
    check_cnt++; if (v !== 1'b1 || d !== 8'h07) $display("FAIL parity_good_byte got=%b/%h exp=1/07", v, d); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_break();
    test_overrun();
    test_push_pop_full();
    test_glitch();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    check_cnt++; if (dbl_cnt != 0) $display("FAIL pulse_width got=%0d exp=0", dbl_cnt); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
